// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port BRAM between the instruction-fetch port
// and the load/store port. At most one access is granted per cycle, with
// round-robin on conflict. Sub-word stores become a read-modify-write sequence,
// because the BRAM only writes whole words. Read data comes back one cycle after
// the grant and is shared by both ports; the rvalid flags say who owns it.
module bram_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:2] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:2] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // BRAM side
  output logic        mem_we,
  output logic [31:2] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_t;

  // Encoding of the round-robin pointer: which port was granted most recently.
  localparam logic LAST_FETCH = 1'b0;
  localparam logic LAST_DATA  = 1'b1;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [31:2] mem_addr_q, mem_addr_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;

  logic        if_win;
  logic        d_win;
  logic        d_be_full;
  logic        d_be_none;
  logic        d_partial;
  logic [31:0] rmw_wdata;

  // Store classification: a full-word store writes directly, an all-zero
  // byte mask is a no-op, anything else needs the old word first.
  assign d_be_full = (d_be == 4'hF);
  assign d_be_none = (d_be == 4'h0);
  assign d_partial = d_we && !d_be_full && !d_be_none;

  // Byte-lane merge for the write half of a read-modify-write. The old word is
  // on mem_rdata during the RMW cycle because the address was presented in the
  // preceding IDLE cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign rmw_wdata[8*gi +: 8] = d_be[gi] ? d_wdata[8*gi +: 8]
                                             : mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Read data is shared by both ports; only the rvalid flags differ.
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;

  // Arbitration: a lone requester wins; on conflict the port that was not
  // granted last wins. Nothing wins while in reset or during the RMW write.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (rst_n && (state_q == ST_IDLE)) begin
      if (if_req && (!d_req || (last_q == LAST_DATA))) begin
        if_win = 1'b1;
      end else if (d_req) begin
        d_win = 1'b1;
      end
    end
  end

  // Next-state logic: a partial store that wins arbitration spends one more
  // cycle in RMW to write the merged word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (d_win && d_partial) begin
          state_d = ST_RMW;
        end
      end
      ST_RMW: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: grants, BRAM address/write controls and write data.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = mem_addr_q;
    mem_wdata = d_wdata;
    case (state_q)
      ST_IDLE: begin
        if (if_win) begin
          if_gnt   = 1'b1;
          mem_addr = if_addr;
        end else if (d_win) begin
          mem_addr = d_addr;
          if (!d_we) begin
            d_gnt = 1'b1;
          end else if (d_be_full) begin
            d_gnt  = 1'b1;
            mem_we = 1'b1;
          end else if (d_be_none) begin
            d_gnt = 1'b1;
          end
          // partial store: read the old word now, grant in the RMW cycle
        end
      end
      ST_RMW: begin
        mem_addr  = d_addr;
        mem_wdata = rmw_wdata;
        // a reset landing on the write cycle must abort the store
        if (rst_n) begin
          d_gnt  = 1'b1;
          mem_we = 1'b1;
        end
      end
      default: begin
        mem_addr = mem_addr_q;
      end
    endcase
  end

  // Next values for the pointer, the held address and the rvalid pipeline.
  always_comb begin
    last_d = last_q;
    if (if_win) begin
      last_d = LAST_FETCH;
    end else if (d_win) begin
      last_d = LAST_DATA;
    end
    mem_addr_d  = mem_addr;
    if_rvalid_d = if_gnt;
    d_rvalid_d  = d_win && !d_we;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Round-robin pointer, held BRAM address and read-valid flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q      <= LAST_DATA;
      mem_addr_q  <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

endmodule
